// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one handshake-driven square-root unit among N_REQ requesters.
// A wait-phase timeout answers the requester with a quiet NaN and an error flag.
module sqrt_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  arg_bus,
    output logic [N_REQ-1:0]     resp_valid,
    output logic                 resp_err,
    output logic [31:0]          result,
    output logic                 unit_start,
    output logic [31:0]          unit_arg,
    input  logic [31:0]          unit_result,
    input  logic                 unit_done,
    output logic                 busy
);
    localparam int          IW          = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IW:0] N_W         = (IW+1)'(N_REQ);
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    localparam logic [31:0] QNAN        = 32'h7FC0_0000;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESPOND} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [31:0]   arg_q, arg_d, result_q, result_d;
    logic          err_q, err_d;

    logic [31:0]          arg_arr [N_REQ];
    logic [2*N_REQ-1:0]   req_dbl;
    logic [N_REQ-1:0]     req_rot;
    logic                 grant_found;
    logic [IW-1:0]        grant_off, grant_idx;
    logic [IW:0]          grant_sum, grant_wrap, ptr_inc;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign arg_arr[gi]    = arg_bus[32*gi +: 32];
            assign resp_valid[gi] = (state_q == RESPOND) && (idx_q == IW'(gi));
        end
    endgenerate

    // Rotate requests so bit 0 is the requester at ptr; lowest set bit then wins.
    assign req_dbl = {req, req} >> ptr_q;
    assign req_rot = req_dbl[N_REQ-1:0];

    always_comb begin
        grant_found = 1'b0;
        grant_off   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant_found = 1'b1;
                grant_off   = IW'(k);
            end
        end
    end

    assign grant_sum  = {1'b0, ptr_q} + {1'b0, grant_off};
    assign grant_wrap = grant_sum - N_W;
    assign grant_idx  = (grant_sum >= N_W) ? grant_wrap[IW-1:0] : grant_sum[IW-1:0];
    assign ptr_inc    = {1'b0, idx_q} + (IW+1)'(1);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        arg_d    = arg_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (grant_found && unit_done) begin
                    idx_d   = grant_idx;
                    arg_d   = arg_arr[grant_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!unit_done) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    result_d = QNAN;
                    err_d    = 1'b1;
                    state_d  = RESPOND;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_DONE: begin
                if (unit_done) begin
                    result_d = unit_result;
                    err_d    = 1'b0;
                    state_d  = RESPOND;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    result_d = QNAN;
                    err_d    = 1'b1;
                    state_d  = RESPOND;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESPOND: begin
                ptr_d   = (ptr_inc >= N_W) ? '0 : ptr_inc[IW-1:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            arg_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            arg_q    <= arg_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign unit_start = (state_q == ISSUE);
    assign busy       = (state_q != IDLE);
    assign resp_err   = (state_q == RESPOND) && err_q;
    assign result     = result_q;
    assign unit_arg   = arg_q;
endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter: a transaction-level model predicts grants, responses
// and latencies every cycle, and literal expectations pin the key scenarios.
module tb_sqrt_arbiter;
    localparam int N   = 4;
    localparam int TO  = 30;
    localparam int LAT = 20;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [32*N-1:0] arg_bus;
    logic [N-1:0]    resp_valid;
    logic            resp_err;
    logic [31:0]     result;
    logic            unit_start;
    logic [31:0]     unit_arg;
    logic [31:0]     unit_result;
    logic            unit_done;
    logic            busy;

    sqrt_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .arg_bus(arg_bus),
        .resp_valid(resp_valid), .resp_err(resp_err), .result(result),
        .unit_start(unit_start), .unit_arg(unit_arg), .unit_result(unit_result),
        .unit_done(unit_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sqrt_lut(input logic [31:0] a);
        case (a)
            32'h4080_0000: return 32'h4000_0000;   // 4  -> 2
            32'h4180_0000: return 32'h4080_0000;   // 16 -> 4
            32'h4110_0000: return 32'h4040_0000;   // 9  -> 3
            32'h3F80_0000: return 32'h3F80_0000;   // 1  -> 1
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    // Square-root unit model: done drops the cycle after start, rises LAT cycles later.
    bit u_deaf = 1'b0;
    bit u_hold_low = 1'b0;
    initial begin
        bit          u_busy;
        int          u_cnt;
        logic [31:0] u_res;
        u_busy = 1'b0; u_cnt = 0; u_res = '0;
        unit_done = 1'b1;
        unit_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (u_hold_low) begin
                unit_done = 1'b0;
            end else if (u_busy) begin
                u_cnt++;
                if (u_cnt == LAT) begin
                    unit_done = 1'b1;
                    unit_result = u_res;
                    u_busy = 1'b0;
                end
            end else begin
                unit_done = 1'b1;
                if (unit_start && !u_deaf) begin
                    unit_done = 1'b0;
                    u_busy = 1'b1;
                    u_cnt = 0;
                    u_res = sqrt_lut(unit_arg);
                end
            end
        end
    end

    // Transaction model and per-cycle compare.
    int          cyc = 0;
    int          start_count = 0;
    int          log_idx[$];
    logic [31:0] log_res[$];
    logic        log_err[$];
    int          log_lat[$];

    initial begin
        bit          pending, is_resp, exp_start;
        int          m_ptr, p_idx, p_start, p_resp, act_idx;
        logic [31:0] p_arg, p_res, m_result, m_arg;
        logic        p_err;
        logic [N-1:0] grant_req, exp_rv;
        pending = 0; exp_start = 0; m_ptr = 0; p_idx = 0; p_start = 0; p_resp = 0;
        p_arg = '0; p_res = '0; m_result = '0; m_arg = '0; p_err = 0; grant_req = '0;
        forever begin
            @(negedge clk);
            cyc++;
            chk("unit_start", {31'b0, unit_start}, {31'b0, exp_start});
            if (unit_start) start_count++;
            if (unit_start && exp_start) begin
                pending = 1;
                p_idx   = rr_pick(grant_req, m_ptr);
                p_arg   = arg_bus[32*p_idx +: 32];
                p_start = cyc;
                p_err   = u_deaf;
                p_res   = u_deaf ? QNAN : sqrt_lut(p_arg);
                p_resp  = cyc + (u_deaf ? TO + 2 : LAT + 1);
                m_arg   = p_arg;
            end
            is_resp = pending && (cyc == p_resp);
            exp_rv  = is_resp ? N'(1 << p_idx) : '0;
            if (is_resp) m_result = p_res;
            chk("resp_valid", {28'b0, resp_valid}, {28'b0, exp_rv});
            chk("resp_err", {31'b0, resp_err}, {31'b0, is_resp && p_err});
            chk("busy", {31'b0, busy}, {31'b0, pending});
            chk("unit_arg", unit_arg, m_arg);
            chk("result", result, m_result);
            if (resp_valid != '0) begin
                act_idx = 0;
                for (int i = N - 1; i >= 0; i--) if (resp_valid[i]) act_idx = i;
                log_idx.push_back(act_idx);
                log_res.push_back(result);
                log_err.push_back(resp_err);
                log_lat.push_back(cyc - p_start);
                $display("resp idx=%0d result=%h err=%0d latency=%0d", act_idx, result, resp_err, cyc - p_start);
            end
            if (is_resp) begin
                m_ptr = (p_idx + 1) % N;
                pending = 0;
            end
            if (reset) begin
                pending = 0; m_ptr = 0; m_result = '0; m_arg = '0; exp_start = 0;
            end else begin
                exp_start = !pending && !is_resp && (req != '0) && unit_done;
            end
            grant_req = req;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Wait until the log holds `target` responses; optionally drop the served request.
    task automatic wait_resp(input int target, input bit drop);
        int n;
        n = 0;
        while (log_idx.size() < target && n < 400) begin
            tick(1);
            n++;
        end
        chk("resp_arrived", {31'b0, log_idx.size() >= target}, 32'd1);
        if (drop && log_idx.size() >= target) req[log_idx[target-1]] = 1'b0;
    endtask

    initial begin
        int base, s0, n;
        int exp_order[5];
        reset = 1'b1;
        req = '0;
        arg_bus = {32'h3F80_0000, 32'h4110_0000, 32'h4180_0000, 32'h4080_0000};
        tick(3);
        reset = 1'b0;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_unit_arg", unit_arg, 32'd0);
        chk("reset_resp_valid", {28'b0, resp_valid}, 32'd0);

        // Single request on requester 0.
        req = 4'b0001;
        wait_resp(1, 1);
        chk("single_idx", log_idx[0], 32'd0);
        chk("single_result", log_res[0], 32'h4000_0000);
        chk("single_err", {31'b0, log_err[0]}, 32'd0);
        chk("single_starts", start_count, 32'd1);
        chk("single_latency", log_lat[0], 32'd21);

        // Pointer wrap: requester 3 alone, then 0 and 3 together.
        tick(2);
        req = 4'b1000;
        wait_resp(2, 1);
        req = 4'b1001;
        wait_resp(3, 1);
        wait_resp(4, 1);
        chk("wrap_first", log_idx[1], 32'd3);
        chk("wrap_second", log_idx[2], 32'd0);
        chk("wrap_third", log_idx[3], 32'd3);

        // Contention with all requests held.
        tick(2);
        base = log_idx.size();
        exp_order = '{0, 1, 2, 3, 0};
        req = 4'b1111;
        for (int i = 1; i <= 5; i++) wait_resp(base + i, 0);
        req = '0;
        for (int i = 0; i < 5; i++) begin
            chk("contend_order", log_idx[base+i], exp_order[i]);
            chk("contend_result", log_res[base+i], sqrt_lut(arg_bus[32*exp_order[i] +: 32]));
        end

        // Timeout: unit never acknowledges.
        tick(2);
        u_deaf = 1'b1;
        base = log_idx.size();
        req = 4'b0100;
        wait_resp(base + 1, 1);
        chk("timeout_idx", log_idx[base], 32'd2);
        chk("timeout_result", log_res[base], 32'h7FC0_0000);
        chk("timeout_err", {31'b0, log_err[base]}, 32'd1);
        chk("timeout_latency", log_lat[base], 32'd32);
        chk("timeout_busy_after", {31'b0, busy}, 32'd0);
        u_deaf = 1'b0;

        // Reset during WAIT_DONE.
        tick(2);
        base = log_idx.size();
        s0 = start_count;
        req = 4'b0001;
        n = 0;
        while (start_count == s0 && n < 50) begin
            tick(1);
            n++;
        end
        chk("rst_op_started", start_count, s0 + 1);
        tick(5);
        reset = 1'b1;
        req = '0;
        tick(1);
        reset = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_unit_arg", unit_arg, 32'd0);
        chk("rst_resp_valid", {28'b0, resp_valid}, 32'd0);
        tick(40);
        chk("rst_no_resp", log_idx.size(), base);

        // Unit not ready: no grant while unit_done is low.
        u_hold_low = 1'b1;
        tick(2);
        s0 = start_count;
        req = 4'b0010;
        tick(10);
        chk("notready_starts", start_count, s0);
        chk("notready_busy", {31'b0, busy}, 32'd0);
        u_hold_low = 1'b0;
        wait_resp(base + 1, 1);
        chk("notready_idx", log_idx[base], 32'd1);
        chk("notready_result", log_res[base], 32'h4080_0000);
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
